// File: rtl/mem_wb_stage_if.sv
// M-stage input bundle and W-stage output bundle of the memory/write-back stage.
// The slave modport is the stage itself; the master modport is whoever drives M.
interface mem_wb_stage_if;
    logic        RegWrite_M;
    logic        MemWrite_M;
    logic [1:0]  ResultSrc_M;
    logic [1:0]  SizeSrc_M;
    logic        LoadSign_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic [4:0]  rd_M;
    logic [31:0] PCPlus4_M;
    logic        Stall_M;
    logic        Flush_M;

    logic        RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [31:0] ALUResult_W;
    logic [31:0] ReadData_W;
    logic [4:0]  rd_W;
    logic [31:0] PCPlus4_W;
    logic        MisalignErr;

    modport master (
        output RegWrite_M, MemWrite_M, ResultSrc_M, SizeSrc_M, LoadSign_M,
               ALUResult_M, WriteData_M, rd_M, PCPlus4_M, Stall_M, Flush_M,
        input  RegWrite_W, ResultSrc_W, ALUResult_W, ReadData_W, rd_W,
               PCPlus4_W, MisalignErr
    );

    modport slave (
        input  RegWrite_M, MemWrite_M, ResultSrc_M, SizeSrc_M, LoadSign_M,
               ALUResult_M, WriteData_M, rd_M, PCPlus4_M, Stall_M, Flush_M,
        output RegWrite_W, ResultSrc_W, ALUResult_W, ReadData_W, rd_W,
               PCPlus4_W, MisalignErr
    );
endinterface

// File: rtl/mem_wb_stage.sv
// RV32 memory-access stage with internal synchronous data RAM and the MEM/WB
// pipeline register. Byte/half/word stores via lane enables, read-first loads
// with sign/zero extension applied after the register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses trap and
// set the sticky MisalignErr; otherwise addresses are aligned down silently).
module mem_wb_stage #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);
    localparam int         DEPTH   = 2 ** (ADDR_WIDTH - 2);
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] RS_LOAD = 2'b01;

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           rdata_q;

    logic [ADDR_WIDTH-3:0] idx;
    logic [1:0]            off_raw;
    logic [1:0]            off_eff;
    logic                  is_half;
    logic                  is_byte;
    logic                  is_word;
    logic                  advance;
    logic                  store_en;
    logic                  load_trap;
    logic                  err_set;
    logic [3:0]            be;
    logic [31:0]           wdata;

    logic        regwrite_q,  regwrite_d;
    logic [1:0]  resultsrc_q, resultsrc_d;
    logic [31:0] alu_q,       alu_d;
    logic [4:0]  rd_q,        rd_d;
    logic [31:0] pc4_q,       pc4_d;
    logic [1:0]  size_q,      size_d;
    logic        sign_q,      sign_d;
    logic [1:0]  off_q,       off_d;
    logic        bubble_q,    bubble_d;
    logic        err_q,       err_d;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    assign idx     = bus.ALUResult_M[ADDR_WIDTH-1:2];
    assign off_raw = bus.ALUResult_M[1:0];
    assign is_half = (bus.SizeSrc_M == SZ_HALF);
    assign is_byte = (bus.SizeSrc_M == SZ_BYTE);
    assign is_word = !is_half && !is_byte;
    assign advance = !bus.Stall_M && !bus.Flush_M;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign  = (is_half && off_raw[0]) || (is_word && (off_raw != 2'b00));
    assign off_eff   = off_raw;
    assign load_trap = misalign && (bus.ResultSrc_M == RS_LOAD);
    assign store_en  = advance && bus.MemWrite_M && !misalign;
    assign err_set   = advance && misalign && (bus.MemWrite_M || (bus.ResultSrc_M == RS_LOAD));
`else
    assign off_eff   = is_word ? 2'b00 : (is_half ? {off_raw[1], 1'b0} : off_raw);
    assign load_trap = 1'b0;
    assign store_en  = advance && bus.MemWrite_M;
    assign err_set   = 1'b0;
`endif

    // Lane enables and lane-replicated store data for the access size
    always_comb begin
        be    = 4'b1111;
        wdata = bus.WriteData_M;
        if (is_byte) begin
            be    = 4'b0001 << off_eff;
            wdata = {4{bus.WriteData_M[7:0]}};
        end else if (is_half) begin
            be    = off_eff[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.WriteData_M[15:0]}};
        end
    end

    // Data RAM: lane-masked write and read-first word read; reset blocks writes but keeps contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            if (store_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            if (!bus.Stall_M) rdata_q <= mem_q[idx];
        end
    end

    // MEM/WB next state: flush inserts a bubble, stall holds, otherwise capture
    always_comb begin
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        alu_d       = alu_q;
        rd_d        = rd_q;
        pc4_d       = pc4_q;
        size_d      = size_q;
        sign_d      = sign_q;
        off_d       = off_q;
        bubble_d    = bubble_q;
        err_d       = err_q | err_set;
        if (bus.Flush_M) begin
            regwrite_d  = 1'b0;
            resultsrc_d = 2'b00;
            alu_d       = '0;
            rd_d        = '0;
            pc4_d       = '0;
            size_d      = 2'b00;
            sign_d      = 1'b0;
            off_d       = 2'b00;
            bubble_d    = 1'b1;
        end else if (!bus.Stall_M) begin
            regwrite_d  = bus.RegWrite_M && !load_trap;
            resultsrc_d = bus.ResultSrc_M;
            alu_d       = bus.ALUResult_M;
            rd_d        = bus.rd_M;
            pc4_d       = bus.PCPlus4_M;
            size_d      = bus.SizeSrc_M;
            sign_d      = bus.LoadSign_M;
            off_d       = off_eff;
            bubble_d    = 1'b0;
        end
    end

    // MEM/WB register with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            alu_q       <= '0;
            rd_q        <= '0;
            pc4_q       <= '0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            off_q       <= 2'b00;
            bubble_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            alu_q       <= alu_d;
            rd_q        <= rd_d;
            pc4_q       <= pc4_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            bubble_q    <= bubble_d;
            err_q       <= err_d;
        end
    end

    // Load extraction from the registered word; bubbles read as zero
    always_comb begin
        byte_sel = rdata_q[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        ext_data = rdata_q;
        if (size_q == SZ_BYTE) begin
            ext_data = {{24{sign_q & byte_sel[7]}}, byte_sel};
        end else if (size_q == SZ_HALF) begin
            ext_data = {{16{sign_q & half_sel[15]}}, half_sel};
        end
        if (bubble_q) ext_data = '0;
    end

    assign bus.RegWrite_W  = regwrite_q;
    assign bus.ResultSrc_W = resultsrc_q;
    assign bus.ALUResult_W = alu_q;
    assign bus.ReadData_W  = ext_data;
    assign bus.rd_W        = rd_q;
    assign bus.PCPlus4_W   = pc4_q;
    assign bus.MisalignErr = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic, scoreboarded
// against a byte-addressed reference memory model.
module tb_mem_wb_stage;
    localparam int AW = 12;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        st;
        logic        fl;
    } min_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        err;
    } wexp_t;

    logic [7:0] mm [0:(1<<AW)-1];
    wexp_t      cur;
    wexp_t      sbq[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: byte memory, aligned-down address, little-endian lanes
    task automatic model(input min_t m);
        int          a, aa, n;
        logic [31:0] v;
        logic        mis;
        a   = int'(m.alu[AW-1:0]);
        n   = (m.sz == 2'b01) ? 2 : (m.sz == 2'b10) ? 1 : 4;
        aa  = a - (a % n);
        mis = (a % n) != 0;
        if (m.fl) begin
            cur = '{rw: 1'b0, rs: 2'b00, alu: 32'h0, rdat: 32'h0, rd: 5'h0, pc4: 32'h0, err: cur.err};
        end else if (!m.st) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v[k*8 +: 8] = mm[aa + k];
            if (m.sg && n == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
            if (m.sg && n == 2 && v[15]) v[31:16] = 16'hFFFF;
            cur.rw   = m.rw && !(TRAP && mis && m.rs == 2'b01);
            cur.rs   = m.rs;
            cur.alu  = m.alu;
            cur.rdat = v;
            cur.rd   = m.rd;
            cur.pc4  = m.pc4;
            if (TRAP && mis && (m.mw || m.rs == 2'b01)) cur.err = 1'b1;
            if (m.mw && !(TRAP && mis))
                for (int k = 0; k < n; k++) mm[aa + k] = m.wd[k*8 +: 8];
        end
    endtask

    task automatic drive(input min_t m);
        bus.RegWrite_M  = m.rw;
        bus.MemWrite_M  = m.mw;
        bus.ResultSrc_M = m.rs;
        bus.SizeSrc_M   = m.sz;
        bus.LoadSign_M  = m.sg;
        bus.ALUResult_M = m.alu;
        bus.WriteData_M = m.wd;
        bus.rd_M        = m.rd;
        bus.PCPlus4_M   = m.pc4;
        bus.Stall_M     = m.st;
        bus.Flush_M     = m.fl;
        model(m);
        sbq.push_back(cur);
    endtask

    task automatic step(input min_t m);
        @(negedge clk);
        drive(m);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic min_t mk_st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        mk_st     = '0;
        mk_st.mw  = 1'b1;
        mk_st.sz  = sz;
        mk_st.alu = a;
        mk_st.wd  = d;
        mk_st.pc4 = a + 32'd4;
    endfunction

    function automatic min_t mk_ld(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        mk_ld     = '0;
        mk_ld.rw  = 1'b1;
        mk_ld.rs  = 2'b01;
        mk_ld.sz  = sz;
        mk_ld.sg  = sg;
        mk_ld.alu = a;
        mk_ld.rd  = 5'd7;
        mk_ld.pc4 = 32'h1000 | a;
    endfunction

    // Monitor: one W-stage sample per clock after the edge, compared with the queue head
    always @(posedge clk) begin
        wexp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({bus.RegWrite_W, bus.ResultSrc_W, bus.ALUResult_W, bus.ReadData_W,
                 bus.rd_W, bus.PCPlus4_W, bus.MisalignErr} !== e) begin
                errors++;
                $display("FAIL wstage actual rw=%b rs=%b alu=%h rd_data=%h rd=%0d pc4=%h err=%b required rw=%b rs=%b alu=%h rd_data=%h rd=%0d pc4=%h err=%b",
                         bus.RegWrite_W, bus.ResultSrc_W, bus.ALUResult_W, bus.ReadData_W,
                         bus.rd_W, bus.PCPlus4_W, bus.MisalignErr,
                         e.rw, e.rs, e.alu, e.rdat, e.rd, e.pc4, e.err);
            end
        end
    end

    initial begin
        min_t m;
        cur = '0;
        bus.RegWrite_M = 1'b0; bus.MemWrite_M = 1'b0; bus.ResultSrc_M = 2'b00;
        bus.SizeSrc_M = 2'b00; bus.LoadSign_M = 1'b0; bus.ALUResult_M = '0;
        bus.WriteData_M = '0; bus.rd_M = '0; bus.PCPlus4_M = '0;
        bus.Stall_M = 1'b0; bus.Flush_M = 1'b0;
        #1;
        chk("reset_regwrite", {31'h0, bus.RegWrite_W}, 32'h0);
        chk("reset_readdata", bus.ReadData_W, 32'h0);
        chk("reset_err", {31'h0, bus.MisalignErr}, 32'h0);

        // Initialise the exercised RAM region (0x00..0x7F) on the release edge onwards
        @(negedge clk);
        rst = 1'b1;
        drive(mk_st(2'b00, 32'h0, $urandom));
        for (int w = 1; w < 32; w++) step(mk_st(2'b00, 32'(w * 4), $urandom));

        // Word store / load and byte extraction
        step(mk_st(2'b00, 32'h10, 32'hDEADBEEF));
        step(mk_ld(2'b00, 1'b0, 32'h10));
        settle(); chk("word_load", bus.ReadData_W, 32'hDEADBEEF);
        step(mk_ld(2'b10, 1'b1, 32'h13));
        settle(); chk("byte_signed", bus.ReadData_W, 32'hFFFFFFDE);
        step(mk_ld(2'b10, 1'b0, 32'h13));
        settle(); chk("byte_unsigned", bus.ReadData_W, 32'h000000DE);

        // Byte lane merge and half load
        step(mk_st(2'b00, 32'h20, 32'h11223344));
        step(mk_st(2'b10, 32'h21, 32'h000000A5));
        step(mk_ld(2'b00, 1'b0, 32'h20));
        settle(); chk("byte_merge", bus.ReadData_W, 32'h1122A544);
        step(mk_ld(2'b01, 1'b1, 32'h22));
        settle(); chk("half_signed", bus.ReadData_W, 32'h00001122);

        // Stalled store must not write; W holds the previous load
        step(mk_st(2'b00, 32'h30, 32'hCAFEF00D));
        step(mk_ld(2'b00, 1'b0, 32'h30));
        m = mk_st(2'b00, 32'h30, 32'h12345678); m.st = 1'b1;
        step(m); step(m);
        settle();
        chk("stall_pc4_hold", bus.PCPlus4_W, 32'h1030);
        chk("stall_rd_hold", bus.ReadData_W, 32'hCAFEF00D);
        step(mk_ld(2'b00, 1'b0, 32'h30));
        settle(); chk("stall_no_write", bus.ReadData_W, 32'hCAFEF00D);
        step(m);
        m.st = 1'b0;
        step(m);
        step(mk_ld(2'b00, 1'b0, 32'h30));
        settle(); chk("stall_release_write", bus.ReadData_W, 32'h12345678);

        // Flush wins over stall
        m = mk_ld(2'b00, 1'b0, 32'h30); m.rd = 5'd9; m.st = 1'b1; m.fl = 1'b1;
        step(m);
        settle();
        chk("flush_regwrite", {31'h0, bus.RegWrite_W}, 32'h0);
        chk("flush_rd", {27'h0, bus.rd_W}, 32'h0);

        // Half store at an odd address
        step(mk_st(2'b00, 32'h40, 32'h11223344));
        step(mk_st(2'b01, 32'h41, 32'h0000BEEF));
        step(mk_ld(2'b00, 1'b0, 32'h40));
        settle();
        chk("half_odd_store", bus.ReadData_W, TRAP ? 32'h11223344 : 32'h1122BEEF);
        chk("misalign_flag", {31'h0, bus.MisalignErr}, {31'h0, TRAP});
        step(mk_ld(2'b00, 1'b0, 32'h44));
        step(mk_ld(2'b00, 1'b0, 32'h48));
        settle();
        chk("misalign_sticky", {31'h0, bus.MisalignErr}, {31'h0, TRAP});

        // Asynchronous reset mid-operation, RAM preserved
        step(mk_ld(2'b00, 1'b0, 32'h10));
        @(posedge clk);
        #3;
        rst = 1'b0;
        cur = '0;
        #1;
        chk("async_rst_alu", bus.ALUResult_W, 32'h0);
        chk("async_rst_pc4", bus.PCPlus4_W, 32'h0);
        chk("async_rst_readdata", bus.ReadData_W, 32'h0);
        @(negedge clk);
        bus.MemWrite_M = 1'b1; bus.SizeSrc_M = 2'b00;
        bus.ALUResult_M = 32'h10; bus.WriteData_M = 32'h0BADF00D;
        bus.RegWrite_M = 1'b1; bus.rd_M = 5'd3;
        settle();
        chk("rst_hold_regwrite", {31'h0, bus.RegWrite_W}, 32'h0);
        chk("rst_hold_rd", {27'h0, bus.rd_W}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(mk_ld(2'b00, 1'b0, 32'h10));
        settle(); chk("ram_kept_over_rst", bus.ReadData_W, 32'hDEADBEEF);

        // Random traffic, including upper-address wrap and stalls/flushes
        for (int i = 0; i < 600; i++) begin
            m     = '0;
            m.rw  = 1'($urandom);
            m.mw  = ($urandom_range(0, 9) < 4);
            m.rs  = 2'($urandom);
            m.sz  = 2'($urandom);
            m.sg  = 1'($urandom);
            m.alu = $urandom & 32'hFFFF_F07F;
            m.wd  = $urandom;
            m.rd  = 5'($urandom);
            m.pc4 = $urandom;
            m.st  = ($urandom_range(0, 99) < 15);
            m.fl  = ($urandom_range(0, 99) < 8);
            step(m);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the pipelined RV32 core, placed directly downstream of the EX/MEM pipeline register. It consumes the M-stage control and data bundle and performs byte, half and word stores and loads into an internal synchronous data RAM. Loads are sign- or zero-extended. The block also contains the MEM/WB pipeline register that feeds the write-back result mux, and it supports stall and flush from the hazard unit.

## Interface
Parameters:
- ADDR_WIDTH, 12: byte-address bits decoded. RAM holds 2^(ADDR_WIDTH-2) 32-bit words.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- RegWrite_M  input  1  register-file write enable
- MemWrite_M  input  1  store request
- ResultSrc_M  input  2  WB select: 00 ALU, 01 load data, 10 PC+4, 11 treated as 00
- SizeSrc_M  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word
- LoadSign_M  input  1  1 = sign-extend load, 0 = zero-extend
- ALUResult_M  input  32  byte address, or ALU result passed through
- WriteData_M  input  32  store data, right-aligned
- rd_M  input  5  destination register
- PCPlus4_M  input  32  link value
- Stall_M  input  1  hold the W register and suppress the store
- Flush_M  input  1  insert a bubble into W
- RegWrite_W  output  1  registered
- ResultSrc_W  output  2  registered
- ALUResult_W  output  32  registered
- ReadData_W  output  32  extended load data, valid in the cycle after capture
- rd_W  output  5  registered
- PCPlus4_W  output  32  registered
- MisalignErr  output  1  sticky misaligned-access flag

## Operation
- Memory array: word-organised, indexed by ALUResult_M[ADDR_WIDTH-1:2]. Higher address bits are ignored, so accesses wrap modulo 2^ADDR_WIDTH. Reset does not clear the RAM.
- Store: on a rising edge with MemWrite_M=1, Stall_M=0 and Flush_M=0:
  - word: writes all 4 lanes.
  - half: writes lanes {off[1],0}+0..1 with WriteData_M[15:0].
  - byte: writes lane off with WriteData_M[7:0].
  - off = ALUResult_M[1:0]. Lanes not selected keep their value.
- Load read: synchronous, read-first. The word is read every non-stalled edge, whatever ResultSrc_M is. Size, sign and offset are registered with the read.
- ReadData_W extraction (combinational from the RAM output and the registered size, sign and offset):
  - byte: lane off, bit 7 extended per sign.
  - half: lanes {off[1],0}, bit 15 extended per sign.
  - word: unchanged.
- W register: on each edge with Stall_M=0, captures RegWrite, ResultSrc, ALUResult, rd and PCPlus4.
  - Flush_M=1 captures a bubble: RegWrite_W=0, rd_W=0, other fields 0.
  - Flush wins over Stall.
  - While stalled, all W outputs and ReadData_W hold, including the RAM output and the registered extraction state.

## Timing
- Latency: M inputs at edge N produce W outputs, including ReadData_W, valid after edge N. One cycle.
- Store at edge N followed by a load to the same word at edge N+1 returns the new data. No internal hazard.
- Reset (rst=0, asynchronous, any time including mid-stall): every W output is 0, ReadData_W=0, MisalignErr=0. No store happens while rst=0. After rst rises, the first edge captures normally.
- Stall with a pending store: no write. The same store completes when the stall releases, with no double write effect.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned means half with off[0]=1, or word with off!=0, on a store or a ResultSrc_M=01 load.
  - Misaligned stores are suppressed.
  - Misaligned loads capture RegWrite_W=0.
  - MisalignErr sets and stays set until reset.
- Undefined:
  - The address is aligned down for the access size (half clears bit 0, word clears bits 1:0). The access proceeds normally.
  - MisalignErr is tied to 0.

## Test plan
- Reset mid-operation: drive rst=0 while W holds data -> all outputs 0 immediately, without waiting for a clock edge. RAM contents are preserved across the reset.
- Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> ReadData_W=0xDEADBEEF one cycle after the load capture. Byte load at 0x13, signed -> 0xFFFFFFDE. Same load unsigned -> 0x000000DE.
- Byte store 0xA5 at 0x21 over a word 0x11223344 at 0x20 -> word read 0x1122A544. Half load at 0x22, signed -> 0x00001122.
- Stall_M=1 for 2 cycles with a store to 0x30 pending -> W outputs frozen and the RAM is unchanged during the stall. The write lands on the release edge.
- Stall_M=1 and Flush_M=1 together -> RegWrite_W=0 and rd_W=0 on the next edge.
- Half store at 0x41:
  - With MEM_MISALIGN_TRAP_EN: no write, MisalignErr=1 and it stays 1.
  - Without it: the store writes lanes 0-1 of word 0x40.
